// File: rtl/alu16_seq.sv
// alu16_seq: sequential 16-bit arithmetic unit for the LR35902 core.
//
// Runs ADD HL,rr / ADD SP,e8 / LD HL,SP+e8 / INC rr / DEC rr as two 8-bit
// passes through an 8-bit adder. The low byte is computed in the accept cycle
// and the high byte in the HI cycle. The result and flags are then held in
// DONE until the consumer takes them.
//
// Optional feature: define ALU16_ADC_EN to enable op 4 = ADC16 and
// op 5 = SBC16. Without the macro, ops 4/5 behave as reserved ops: the result
// is a and the flags pass through unchanged.
//
// Ports:
//   clk        in   core clock
//   reset      in   synchronous, active-high
//   in_valid   in   operation request
//   in_ready   out  unit idle; accept on in_valid & in_ready
//   op         in   [2:0] 0=ADD16 1=ADDSP 2=INC16 3=DEC16 4=ADC16 5=SBC16
//   a          in   [15:0] first operand (HL, SP or rr)
//   b          in   [15:0] second operand (b[7:0] = signed e8 for ADDSP)
//   flags_in   in   [3:0] current {Z,N,H,C}
//   out_valid  out  result/flags_out valid
//   out_ready  in   consumer accepts
//   result     out  [15:0] 16-bit result
//   flags_out  out  [3:0] updated {Z,N,H,C}
module alu16_seq #(
  parameter bit FLAG_MASK_ON_ADDSP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [3:0]  flags_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic [3:0]  flags_out
);

  typedef enum logic [1:0] {ST_IDLE, ST_HI, ST_DONE} state_t;

  localparam logic [2:0] OP_ADD16 = 3'd0;
  localparam logic [2:0] OP_ADDSP = 3'd1;
  localparam logic [2:0] OP_INC16 = 3'd2;
  localparam logic [2:0] OP_DEC16 = 3'd3;
`ifdef ALU16_ADC_EN
  localparam logic [2:0] OP_ADC16 = 3'd4;
  localparam logic [2:0] OP_SBC16 = 3'd5;
`endif

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [7:0]  a_hi_q, a_hi_d;
  logic [7:0]  bop_hi_q, bop_hi_d;
  logic [3:0]  flags_in_q, flags_in_d;
  logic [7:0]  lo_q, lo_d;
  logic        c8_q, c8_d;
  logic        c4_q, c4_d;
  logic [15:0] result_q, result_d;
  logic [3:0]  flags_out_q, flags_out_d;

  logic [15:0] bop;
  logic        cin;
  logic [8:0]  lo_sum;
  logic [8:0]  hi_sum;
  logic        c4;
  logic        c12;
  logic [15:0] hi_res;
  logic [3:0]  flags_calc;

  // Second-operand form and carry-in. Subtraction inverts the operand and the
  // incoming carry, so the adder's carries come out as inverted borrows.
  // Reserved ops add zero, which passes a through unchanged.
  always_comb begin
    bop = 16'h0000;
    cin = 1'b0;
    case (op)
      OP_ADD16: bop = b;
      OP_ADDSP: bop = {{8{b[7]}}, b[7:0]};
      OP_INC16: bop = 16'h0001;
      OP_DEC16: bop = 16'hFFFF;
`ifdef ALU16_ADC_EN
      OP_ADC16: begin
        bop = b;
        cin = flags_in[0];
      end
      OP_SBC16: begin
        bop = ~b;
        cin = ~flags_in[0];
      end
`endif
      default: ;
    endcase
  end

  // Each byte pass is one 9-bit add. The carry into bit 4 of a byte is
  // recovered as sum ^ a ^ b at that bit, so no separate nibble adder is
  // needed.
  always_comb begin
    lo_sum = {1'b0, a[7:0]} + {1'b0, bop[7:0]} + {8'h00, cin};
    c4     = lo_sum[4] ^ a[4] ^ bop[4];
    hi_sum = {1'b0, a_hi_q} + {1'b0, bop_hi_q} + {8'h00, c8_q};
    c12    = hi_sum[4] ^ a_hi_q[4] ^ bop_hi_q[4];
    hi_res = {hi_sum[7:0], lo_q};
  end

  // Flag update for the op held in the HI cycle.
  always_comb begin
    flags_calc = flags_in_q;
    case (op_q)
      OP_ADD16: flags_calc = {flags_in_q[3], 1'b0, c12, hi_sum[8]};
      OP_ADDSP: flags_calc = {(FLAG_MASK_ON_ADDSP ? 1'b0 : flags_in_q[3]),
                              1'b0, c4_q, c8_q};
`ifdef ALU16_ADC_EN
      OP_ADC16: flags_calc = {(hi_res == 16'h0000), 1'b0, c12, hi_sum[8]};
      OP_SBC16: flags_calc = {(hi_res == 16'h0000), 1'b1, ~c12, ~hi_sum[8]};
`endif
      default: flags_calc = flags_in_q;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_HI;
      ST_HI:   state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers. Operands and the low-byte pass are captured at
  // accept. The result is written only when leaving HI, so it stays stable
  // through DONE under backpressure.
  always_comb begin
    op_d        = op_q;
    a_hi_d      = a_hi_q;
    bop_hi_d    = bop_hi_q;
    flags_in_d  = flags_in_q;
    lo_d        = lo_q;
    c8_d        = c8_q;
    c4_d        = c4_q;
    result_d    = result_q;
    flags_out_d = flags_out_q;
    if (state_q == ST_IDLE && in_valid) begin
      op_d       = op;
      a_hi_d     = a[15:8];
      bop_hi_d   = bop[15:8];
      flags_in_d = flags_in;
      lo_d       = lo_sum[7:0];
      c8_d       = lo_sum[8];
      c4_d       = c4;
    end
    if (state_q == ST_HI) begin
      result_d    = hi_res;
      flags_out_d = flags_calc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= 3'd0;
      a_hi_q      <= 8'h00;
      bop_hi_q    <= 8'h00;
      flags_in_q  <= 4'h0;
      lo_q        <= 8'h00;
      c8_q        <= 1'b0;
      c4_q        <= 1'b0;
      result_q    <= 16'h0000;
      flags_out_q <= 4'h0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_hi_q      <= a_hi_d;
      bop_hi_q    <= bop_hi_d;
      flags_in_q  <= flags_in_d;
      lo_q        <= lo_d;
      c8_q        <= c8_d;
      c4_q        <= c4_d;
      result_q    <= result_d;
      flags_out_q <= flags_out_d;
    end
  end

  // Handshake outputs follow the state directly.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    result    = result_q;
    flags_out = flags_out_q;
  end

endmodule

// File: doc/alu16_seq.md
Name: alu16_seq

Overview:
- Sequential 16-bit arithmetic unit for the LR35902 core.
- Executes ADD HL,rr / ADD SP,e8 / LD HL,SP+e8 / INC rr / DEC rr as two 8-bit passes through the core's 8-bit add/sub datapath: low byte first, high byte second.
- Sits between the register-file read stage and the writeback/flag stage.
- Valid/ready on both sides; produces the 16-bit result plus the updated ZNHC flag nibble.

Parameters:
- FLAG_MASK_ON_ADDSP, 1, 1 = ADDSP forces Z=0 and N=0 (LR35902 behaviour); 0 = Z passes through from flags_in.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  unit idle; request accepted when in_valid & in_ready at a clk edge.
- op  in  3  0=ADD16, 1=ADDSP, 2=INC16, 3=DEC16, 4=ADC16, 5=SBC16, 6/7=reserved.
- a  in  16  first operand (HL, SP, or rr).
- b  in  16  second operand; ADDSP uses b[7:0] as signed e8; ignored for INC16/DEC16.
- flags_in  in  4  current flags {Z,N,H,C}.
- out_valid  out  1  result and flags_out valid.
- out_ready  in  1  consumer accepts; transfer when out_valid & out_ready.
- result  out  16  16-bit result.
- flags_out  out  4  updated {Z,N,H,C}.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, flags_out=0. Reset mid-operation aborts with no output; out_valid=0 the cycle after reset.
- FSM: IDLE -> HI -> DONE -> IDLE.
  - IDLE: in_ready=1. On accept, latch op, a, flags_in; compute the low byte, its carry c8 and low-nibble carry c4; go to HI.
  - HI: compute the high byte with carry-in c8, record c12 (carry out of bit 11) and c16; go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Latency and throughput:
  - Accept at edge T; out_valid=1 after edge T+2.
  - in_ready=0 in HI and DONE; there is no accept in the same cycle as the output handshake.
  - Throughput: 1 op per 3 cycles at full out_ready.
- Backpressure: result and flags_out held stable while out_valid=1 and out_ready=0.
- Operand forms (all arithmetic mod 2^16):
  - ADD16: a + b.
  - ADDSP: a + sign_extend(b[7:0]); the high byte adds {8{b[7]}} + c8.
  - INC16: a + 0x0001.
  - DEC16: a + 0xFFFF.
- Flags:
  - ADD16: Z=flags_in.Z, N=0, H=c12, C=c16.
  - ADDSP: Z=0, N=0, H=c4, C=c8 (flags from the low byte only).
  - INC16/DEC16: flags_out = flags_in unchanged.
- Reserved ops 6/7 (and 4/5 without the macro): result=a, flags_out=flags_in, same 2-cycle latency.
- Subtraction is done as an inverted operand with carry-in; carry and half-carry outputs are then complemented to borrows.

Optional Feature:
- Macro ALU16_ADC_EN.
- Defined: op 4 = ADC16, op 5 = SBC16, both 16-bit.
  - Carry-in to the low byte = flags_in.C.
  - ADC16: N=0.
  - SBC16: N=1; H = borrow from bit 12; C = borrow from bit 16.
  - Both: Z = (result==0).
- Undefined: ops 4/5 behave as reserved (result=a, flags passthrough); no ADC/SBC logic is synthesized.

Test Plan:
- ADD16 a=0x0FFF b=0x0001 flags_in=1000 -> result 0x1000, flags_out 1010, out_valid exactly 2 cycles after accept.
- ADD16 a=0xFFFF b=0x0001 flags_in=0000 -> 0x0000, flags_out 0011 (Z not set); ADDSP a=0xFFF8 b=0x0008 -> 0x0000, flags_out 0011.
- ADDSP a=0x1000 b=0x00FF -> 0x0FFF, flags_out 0000; INC16 a=0xFFFF flags_in=1111 -> 0x0000, 1111; DEC16 a=0x0000 -> 0xFFFF, flags unchanged.
- Backpressure: ADD16 0x1234+0x1111, out_ready=0 for 3 cycles -> result 0x2345 held, in_ready=0 throughout; accept on the 4th cycle, in_ready=1 on the next.
- Assert reset in HI during ADD16 -> out_valid stays 0, in_ready=1 after the reset edge; a following INC16 0x00FF -> 0x0100.
- With ALU16_ADC_EN: SBC16 a=0x1000 b=0x0001 flags_in C=1 -> 0x0FFE, flags_out 0110; ADC16 a=0xFFFF b=0x0000 C=1 -> 0x0000, flags_out 1011.
